multicycle_controller: RTL

Sequencing controller for the multi-cycle RV32I core variant, where one ALU, one unified memory port and one register file are shared across 3–5 cycles per instruction. A Moore state machine decodes the latched instruction fields. Each cycle it drives the datapath multiplexer selects, write enables and ALU control. It stalls on a memory ready handshake, so instruction and data memory may insert wait states.

---
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared RV32I datapath.
// master = controller side (drives selects/enables), slave = datapath side.
interface multicycle_controller_if;
   logic [6:0] i_op;
   logic [2:0] i_funct3;
   logic       i_funct7_5;
   logic       i_zero;
   logic       i_mem_ready;
   logic       o_pc_write;
   logic       o_adr_src;
   logic       o_mem_write;
   logic       o_ir_write;
   logic       o_reg_write;
   logic [1:0] o_result_src;
   logic [1:0] o_alu_src_a;
   logic [1:0] o_alu_src_b;
   logic [1:0] o_immsrc;
   logic [2:0] o_alu_ctrl;
   logic       o_illegal;
   logic [3:0] o_state;

   modport master (
      input  i_op, i_funct3, i_funct7_5, i_zero, i_mem_ready,
      output o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write,
             o_result_src, o_alu_src_a, o_alu_src_b, o_immsrc, o_alu_ctrl,
             o_illegal, o_state
   );

   modport slave (
      output i_op, i_funct3, i_funct7_5, i_zero, i_mem_ready,
      input  o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write,
             o_result_src, o_alu_src_a, o_alu_src_b, o_immsrc, o_alu_ctrl,
             o_illegal, o_state
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: Moore FSM with registered per-state controls, stalls on i_mem_ready.
// ILLEGAL_TRAP_EN: when defined, unlisted opcodes enter HALT and set a sticky o_illegal.
module multicycle_controller (
   input  logic i_clk,
   input  logic i_rst,
   multicycle_controller_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALRADR  = 4'd11,
      JALRPC   = 4'd12,
      HALT     = 4'd15
   } state_t;

   typedef struct packed {
      logic       adr_src;
      logic       pc_write;
      logic       reg_write;
      logic       mem_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
   } ctrl_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5,
                                            input logic f75);
      logic [2:0] a;
      case (f3)
         3'b000:  a = (op5 & f75) ? ALU_SUB : ALU_ADD;
         3'b010:  a = ALU_SLT;
         3'b110:  a = ALU_OR;
         3'b111:  a = ALU_AND;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   // Static (ungated) control word for the state about to be entered.
   function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] f3,
                                        input logic op5, input logic f75);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         DECODE: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b01;
         end
         MEMADR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
         end
         MEMREAD:  c.adr_src = 1'b1;
         MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         EXECR: begin
            c.alu_src_a = 2'b10;
            c.alu_ctrl  = funct_alu(f3, op5, f75);
         end
         EXECI: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
            c.alu_ctrl  = funct_alu(f3, op5, f75);
         end
         ALUWB:    c.reg_write = 1'b1;
         BRANCH: begin
            c.alu_src_a = 2'b10;
            c.alu_ctrl  = ALU_SUB;
         end
         JAL, JALRPC: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
            c.pc_write  = 1'b1;
         end
         JALRADR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t state;
   state_t state_nxt;
   ctrl_t  ctrl;
   logic   br_eq;
   logic   br_ne;

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:    state_nxt = bus.i_mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (bus.i_op)
               OP_LOAD, OP_STORE: state_nxt = MEMADR;
               OP_R:              state_nxt = EXECR;
               OP_I:              state_nxt = EXECI;
               OP_B:              state_nxt = BRANCH;
               OP_JAL:            state_nxt = JAL;
               OP_JALR:           state_nxt = JALRADR;
`ifdef ILLEGAL_TRAP_EN
               default:           state_nxt = HALT;
`else
               default:           state_nxt = FETCH;
`endif
            endcase
         end
         MEMADR:   state_nxt = bus.i_op[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  state_nxt = bus.i_mem_ready ? MEMWB : MEMREAD;
         MEMWB:    state_nxt = FETCH;
         MEMWRITE: state_nxt = bus.i_mem_ready ? FETCH : MEMWRITE;
         EXECR:    state_nxt = ALUWB;
         EXECI:    state_nxt = ALUWB;
         ALUWB:    state_nxt = FETCH;
         BRANCH:   state_nxt = FETCH;
         JAL:      state_nxt = ALUWB;
         JALRADR:  state_nxt = JALRPC;
         JALRPC:   state_nxt = ALUWB;
         HALT:     state_nxt = HALT;
         default:  state_nxt = FETCH;
      endcase
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= FETCH;
         ctrl  <= state_ctrl(FETCH, 3'b000, 1'b0, 1'b0);
         br_eq <= 1'b0;
         br_ne <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         ctrl  <= state_ctrl(state_nxt, bus.i_funct3, bus.i_op[5], bus.i_funct7_5);
         br_eq <= (state_nxt == BRANCH) && (bus.i_funct3 == 3'b000);
         br_ne <= (state_nxt == BRANCH) && (bus.i_funct3 == 3'b001);
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= illegal_q | (state_nxt == HALT);
`endif
      end
   end

`ifdef ILLEGAL_TRAP_EN
   assign bus.o_illegal = illegal_q;
`else
   assign bus.o_illegal = 1'b0;
`endif

   // Enables are masked while reset is held so nothing fires with state already forced to FETCH.
   assign bus.o_pc_write  = !i_rst & (ctrl.pc_write
                                      | ((state == FETCH) & bus.i_mem_ready)
                                      | (br_eq & bus.i_zero)
                                      | (br_ne & !bus.i_zero));
   assign bus.o_ir_write  = !i_rst & (state == FETCH) & bus.i_mem_ready;
   assign bus.o_mem_write = !i_rst & ctrl.mem_write;
   assign bus.o_reg_write = !i_rst & ctrl.reg_write;
   assign bus.o_adr_src    = ctrl.adr_src;
   assign bus.o_result_src = ctrl.result_src;
   assign bus.o_alu_src_a  = ctrl.alu_src_a;
   assign bus.o_alu_src_b  = ctrl.alu_src_b;
   assign bus.o_alu_ctrl   = ctrl.alu_ctrl;
   assign bus.o_state      = state;

   always_comb begin
      bus.o_immsrc = 2'b00;
      case (bus.i_op)
         OP_STORE: bus.o_immsrc = 2'b01;
         OP_B:     bus.o_immsrc = 2'b10;
         OP_JAL:   bus.o_immsrc = 2'b11;
         default:  bus.o_immsrc = 2'b00;
      endcase
   end

endmodule
